// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int STATE_W          = 2;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_FLUSH_CYCLES = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    FLUSH_HOLD = 2'd2,
    FLUSH_WAIT = 2'd3
  } arb_state_t;

  // Increment modulo n, for ring pointers whose size need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  int j;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (!found && req[j]) begin
        found = 1'b1;
        index = IW'(j);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the general_fifo write port with burst lock and flush sequencing.
// Optional per-requester word counters are enabled by defining FIFO_WRITE_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWIDTH       = 32,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                        write_clock,
  input  logic                        write_reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DWIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        flush_req,
  output logic                        flush_done,
  input  logic                        fifo_almost_full,
  output logic                        fifo_write_enable,
  output logic [DWIDTH-1:0]           fifo_write_data,
  output logic                        fifo_flush,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef FIFO_WRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]       word_count
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int FW = $clog2(FLUSH_CYCLES);

  arb_state_t    state, state_next;
  logic [IW-1:0] rr_ptr, rr_ptr_next;
  logic [IW-1:0] grant_id_next;
  logic [BW-1:0] burst_cnt, burst_next;
  logic [FW-1:0] flush_cnt, flush_cnt_next;
  logic          flush_pending, flush_pending_next;
  logic          pick_found;
  logic [IW-1:0] pick_index;
  logic [IW-1:0] ptr_after_grant;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_index)
  );

  assign ptr_after_grant = IW'(wrap_inc(32'(grant_id), NUM_REQ));

  // Next-state, ack and bookkeeping; a pending flush cuts the grant at the next word boundary.
  always_comb begin
    state_next         = state;
    rr_ptr_next        = rr_ptr;
    grant_id_next      = grant_id;
    burst_next         = burst_cnt;
    flush_cnt_next     = flush_cnt;
    flush_pending_next = flush_pending | flush_req;
    ack                = '0;
    case (state)
      IDLE: begin
        if (flush_pending) begin
          state_next     = FLUSH_HOLD;
          flush_cnt_next = FW'(FLUSH_CYCLES - 1);
        end else if (pick_found) begin
          state_next    = GRANT;
          grant_id_next = pick_index;
          burst_next    = '0;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (flush_pending) begin
          state_next  = IDLE;
          rr_ptr_next = ptr_after_grant;
        end else if (fifo_almost_full) begin
          state_next = GRANT;
        end else if (req[grant_id]) begin
          ack[grant_id] = 1'b1;
          burst_next    = burst_cnt + BW'(1);
          if (req_last[grant_id] || (burst_cnt == BW'(MAX_BURST - 1))) begin
            state_next  = IDLE;
            rr_ptr_next = ptr_after_grant;
          end else begin
            state_next = GRANT;
          end
        end else begin
          state_next  = IDLE;
          rr_ptr_next = ptr_after_grant;
        end
      end
      FLUSH_HOLD: begin
        flush_pending_next = 1'b1;
        if (flush_cnt == '0) begin
          state_next = FLUSH_WAIT;
        end else begin
          flush_cnt_next = flush_cnt - FW'(1);
        end
      end
      FLUSH_WAIT: begin
        flush_pending_next = 1'b0;
        rr_ptr_next        = '0;
        state_next         = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered FIFO-side outputs; fifo_flush/flush_done/busy mirror the state entered.
  always_ff @(posedge write_clock or posedge write_reset) begin
    if (write_reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant_id          <= '0;
      burst_cnt         <= '0;
      flush_cnt         <= '0;
      flush_pending     <= 1'b0;
      fifo_write_enable <= 1'b0;
      fifo_write_data   <= '0;
      fifo_flush        <= 1'b0;
      flush_done        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_next;
      rr_ptr            <= rr_ptr_next;
      grant_id          <= grant_id_next;
      burst_cnt         <= burst_next;
      flush_cnt         <= flush_cnt_next;
      flush_pending     <= flush_pending_next;
      fifo_write_enable <= |ack;
      fifo_write_data   <= (|ack) ? req_data[grant_id*DWIDTH +: DWIDTH] : fifo_write_data;
      fifo_flush        <= (state_next == FLUSH_HOLD);
      flush_done        <= (state_next == FLUSH_WAIT);
      busy              <= (state_next != IDLE);
    end
  end

`ifdef FIFO_WRITE_ARB_STATS_EN
  // Per-requester accepted-word counters, cleared when a flush completes.
  always_ff @(posedge write_clock or posedge write_reset) begin
    if (write_reset) begin
      word_count <= '0;
    end else if (state == FLUSH_WAIT) begin
      word_count <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (ack[k]) begin
          word_count[k*32 +: 32] <= word_count[k*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table plus directed multi-cycle sequences.
module tb_fifo_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic         flush_req;
  logic         af;
  logic [3:0]   ack, ack_b;
  logic         fd, fd_b, we, we_b, ff, ff_b, busy, busy_b;
  logic [31:0]  wd, wd_b;
  logic [1:0]   gid, gid_b;
`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [127:0] wc, wc_b;
`endif

  int errors = 0;
  int checks = 0;
  int na, nw, cnt, exp_gid, phase;
  logic [3:0] exp_ack;
  logic       done;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(4), .DWIDTH(32), .MAX_BURST(16), .FLUSH_CYCLES(8)) dut (
    .write_clock(clk), .write_reset(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .flush_req(flush_req), .flush_done(fd), .fifo_almost_full(af),
    .fifo_write_enable(we), .fifo_write_data(wd), .fifo_flush(ff), .grant_id(gid), .busy(busy)
`ifdef FIFO_WRITE_ARB_STATS_EN
    , .word_count(wc)
`endif
  );

  fifo_write_arbiter #(.NUM_REQ(4), .DWIDTH(32), .MAX_BURST(4), .FLUSH_CYCLES(8)) dut_b (
    .write_clock(clk), .write_reset(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack_b), .flush_req(flush_req), .flush_done(fd_b), .fifo_almost_full(af),
    .fifo_write_enable(we_b), .fifo_write_data(wd_b), .fifo_flush(ff_b), .grant_id(gid_b), .busy(busy_b)
`ifdef FIFO_WRITE_ARB_STATS_EN
    , .word_count(wc_b)
`endif
  );

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  l;
    logic [31:0] base;
    logic [3:0]  ack;
    logic        we;
    logic [31:0] wd;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lane k carries base + k<<28 so a wrong lane select shows up in the data.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic a,
                       input logic f, input logic [31:0] base);
    req       = r;
    req_last  = l;
    af        = a;
    flush_req = f;
    for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = base + (32'(k) << 28);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

    tbl[0]  = '{4'b0010, 4'b0000, 32'h100, 4'b0000, 1'b0, 32'h0,         2'd0, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0000, 32'h101, 4'b0010, 1'b0, 32'h0,         2'd1, 1'b1};
    tbl[2]  = '{4'b0010, 4'b0000, 32'h102, 4'b0010, 1'b1, 32'h1000_0101, 2'd1, 1'b1};
    tbl[3]  = '{4'b0010, 4'b0000, 32'h103, 4'b0010, 1'b1, 32'h1000_0102, 2'd1, 1'b1};
    tbl[4]  = '{4'b0010, 4'b0000, 32'h104, 4'b0010, 1'b1, 32'h1000_0103, 2'd1, 1'b1};
    tbl[5]  = '{4'b0010, 4'b0010, 32'h105, 4'b0010, 1'b1, 32'h1000_0104, 2'd1, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 32'h106, 4'b0000, 1'b1, 32'h1000_0105, 2'd1, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 32'h107, 4'b0000, 1'b0, 32'h0,         2'd1, 1'b0};
    tbl[8]  = '{4'b0101, 4'b0000, 32'h108, 4'b0000, 1'b0, 32'h0,         2'd1, 1'b0};
    tbl[9]  = '{4'b0101, 4'b0000, 32'h109, 4'b0100, 1'b0, 32'h0,         2'd2, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 32'h10a, 4'b0000, 1'b1, 32'h2000_0109, 2'd2, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 32'h10b, 4'b0000, 1'b0, 32'h0,         2'd2, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ack", 32'(ack), 32'h0);
    chk("reset we", 32'(we), 32'h0);
    chk("reset wdata", wd, 32'h0);
    chk("reset flush", 32'(ff), 32'h0);
    chk("reset done", 32'(fd), 32'h0);
    chk("reset gid", 32'(gid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);

    // Single requester 1, five words, then rr_ptr=2 shown by picking 2 over 0.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].l, 1'b0, 1'b0, tbl[i].base);
      #1;
      chk($sformatf("vec%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("vec%0d we", i), 32'(we), 32'(tbl[i].we));
      chk($sformatf("vec%0d gid", i), 32'(gid), 32'(tbl[i].gid));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].we) chk($sformatf("vec%0d wdata", i), wd, tbl[i].wd);
    end

    // Fairness on the MAX_BURST=4 instance: 0,1,2,3,0 with one arbitration cycle between bursts.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      drive(4'b1111, 4'b0000, 1'b0, 1'b0, 32'h400 + 32'(c));
      #1;
      phase   = c % 5;
      exp_gid = (c / 5) % 4;
      exp_ack = (phase == 0) ? 4'b0000 : (4'b0001 << exp_gid);
      chk($sformatf("fair%0d ack", c), 32'(ack_b), 32'(exp_ack));
      chk($sformatf("fair%0d busy", c), 32'(busy_b), (phase != 0) ? 32'd1 : 32'd0);
      chk($sformatf("fair%0d we", c), 32'(we_b), (c > 0 && phase != 1) ? 32'd1 : 32'd0);
      if (phase != 0) chk($sformatf("fair%0d gid", c), 32'(gid_b), 32'(exp_gid));
      if (we_b) chk($sformatf("fair%0d wdata", c), wd_b, 32'h400 + 32'(c - 1) + (32'(gid_b) << 28));
      chk($sformatf("fair%0d flush", c), 32'(ff_b | fd_b), 32'h0);
    end

    // Backpressure: almost_full for 10 cycles mid-packet on requester 3.
    do_reset();
    na = 0;
    nw = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      drive((na < 6) ? 4'b1000 : 4'b0000, (na == 5) ? 4'b1000 : 4'b0000,
            (c >= 3 && c < 13), 1'b0, 32'h200 + 32'(na));
      #1;
      if (af) chk($sformatf("bp%0d ack", c), 32'(ack), 32'h0);
      if (af && c >= 4) chk($sformatf("bp%0d we", c), 32'(we), 32'h0);
      if (af) chk($sformatf("bp%0d gid", c), 32'(gid), 32'd3);
      if (af) chk($sformatf("bp%0d busy", c), 32'(busy), 32'd1);
      if (ack[3]) na++;
      if (we) begin
        chk($sformatf("bp%0d wdata", c), wd, 32'h3000_0200 + 32'(nw));
        nw++;
      end
      done = (na == 6) && (nw == 6);
    end
    chk("bp acks", 32'(na), 32'd6);
    chk("bp writes", 32'(nw), 32'd6);

    // Flush during word 3 of an 8-word packet; a second flush_req mid-hold is absorbed.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      drive((c < 5) ? 4'b0001 : 4'b0101, 4'b0000, 1'b0, (c == 3 || c == 8), 32'h300 + 32'(c));
      #1;
      exp_ack = ((c >= 1 && c <= 3) || c == 16) ? 4'b0001 : 4'b0000;
      chk($sformatf("fl%0d ack", c), 32'(ack), 32'(exp_ack));
      chk($sformatf("fl%0d we", c), 32'(we), (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("fl%0d flush", c), 32'(ff), (c >= 6 && c <= 13) ? 32'd1 : 32'd0);
      chk($sformatf("fl%0d done", c), 32'(fd), (c == 14) ? 32'd1 : 32'd0);
      chk($sformatf("fl%0d busy", c), 32'(busy),
          ((c >= 1 && c <= 4) || (c >= 6 && c <= 14) || c == 16) ? 32'd1 : 32'd0);
      if (c == 4) chk("fl word3 data", wd, 32'h0000_0303);
      if (c == 16) chk("fl regrant gid", 32'(gid), 32'd0);
    end

    // Reset in FLUSH_HOLD after a grant to requester 1 (rr_ptr=2).
    do_reset();
    @(negedge clk); drive(4'b0010, 4'b0010, 1'b0, 1'b0, 32'h500);
    @(negedge clk); drive(4'b0010, 4'b0010, 1'b0, 1'b0, 32'h501);
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h502);
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 10) begin
      @(negedge clk);
      drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h503);
      #1;
      done = ff;
      cnt++;
    end
    chk("rst flush seen", 32'(done), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst ff", 32'(ff), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst gid", 32'(gid), 32'h0);
    chk("rst we", 32'(we), 32'h0);
    chk("rst done", 32'(fd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); drive(4'b0110, 4'b0000, 1'b0, 1'b0, 32'h600);
    @(negedge clk); drive(4'b0110, 4'b0000, 1'b0, 1'b0, 32'h601);
    #1;
    chk("post-rst gid", 32'(gid), 32'd1);
    chk("post-rst ack", 32'(ack), 32'b0010);

`ifdef FIFO_WRITE_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      for (int c = 0; c < 40 && cnt < ((p == 0) ? 3 : 7); c++) begin
        @(negedge clk);
        drive((p == 0) ? 4'b0001 : 4'b0100,
              (cnt == ((p == 0) ? 2 : 6)) ? ((p == 0) ? 4'b0001 : 4'b0100) : 4'b0000,
              1'b0, 1'b0, 32'h700);
        #1;
        if (|ack) cnt++;
      end
      @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    end
    @(negedge clk);
    #1;
    chk("stats0", wc[31:0], 32'd3);
    chk("stats1", wc[63:32], 32'd0);
    chk("stats2", wc[95:64], 32'd7);
    chk("stats3", wc[127:96], 32'd0);
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0);
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
      #1;
      done = fd;
      cnt++;
    end
    chk("stats flush done", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk("stats cleared", 32'(|wc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
